// File: rtl/smith_waterman_rd_ctrl_if.sv
// ----------------------------------------------------------------------------
// smith_waterman_rd_ctrl_if
//   Bundles the memory read port (request/response) and the FIFO enqueue side
//   used by smith_waterman_rd_ctrl.
//   master : controller side (drives requests and FIFO enqueues)
//   slave  : memory / FIFO side
//   Signals:
//     rd_req_valid, rd_req_addr[ADDR_W]  request toward memory
//     rd_req_ready                       memory accepts request this cycle
//     rd_rsp_valid, rd_rsp_data[512]     in-order read response
//     fifo_enq_en, fifo_enq_data[512]    FIFO enqueue
//     fifo_count[$clog2(FIFO_DEPTH)+1]   current FIFO byte occupancy
// ----------------------------------------------------------------------------
interface smith_waterman_rd_ctrl_if #(
   parameter int ADDR_W     = 42,
   parameter int FIFO_DEPTH = 512
);
   logic                          rd_req_valid;
   logic [ADDR_W-1:0]             rd_req_addr;
   logic                          rd_req_ready;
   logic                          rd_rsp_valid;
   logic [511:0]                  rd_rsp_data;
   logic                          fifo_enq_en;
   logic [511:0]                  fifo_enq_data;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;

   modport master (
      output rd_req_valid, rd_req_addr, fifo_enq_en, fifo_enq_data,
      input  rd_req_ready, rd_rsp_valid, rd_rsp_data, fifo_count
   );

   modport slave (
      input  rd_req_valid, rd_req_addr, fifo_enq_en, fifo_enq_data,
      output rd_req_ready, rd_rsp_valid, rd_rsp_data, fifo_count
   );
endinterface

// File: rtl/smith_waterman_rd_ctrl.sv
// ----------------------------------------------------------------------------
// smith_waterman_rd_ctrl
//   Streams a sequence string from host memory into the smith_waterman byte
//   FIFO. Issues 64-byte line reads under credit flow control (FIFO occupancy
//   plus in-flight lines) and a cap on in-flight requests, forwards responses
//   as FIFO enqueues through a one-cycle register, and pulses done after the
//   last enqueue.
//   Ports:
//     clk, reset_n (async, active low)
//     start       one-cycle pulse, sampled only in IDLE
//     base_addr   first line address, latched on start
//     num_lines   line count, latched on start
//     busy        high in ISSUE or DRAIN
//     done        one-cycle pulse in DONE
//     bus         smith_waterman_rd_ctrl_if.master (memory + FIFO side)
//   Optional (macro SW_RD_CTRL_PERF_EN):
//     perf_busy_cycles   saturating count of busy cycles
//     perf_credit_stall  saturating count of ISSUE cycles blocked by credit/cap
// ----------------------------------------------------------------------------
module smith_waterman_rd_ctrl #(
   parameter int FIFO_DEPTH      = 512,
   parameter int ADDR_W          = 42,
   parameter int LEN_W           = 32,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  num_lines,
   output logic              busy,
   output logic              done,
`ifdef SW_RD_CTRL_PERF_EN
   output logic [31:0]       perf_busy_cycles,
   output logic [31:0]       perf_credit_stall,
`endif
   smith_waterman_rd_ctrl_if.master bus
);

   localparam int CW = $clog2(FIFO_DEPTH) + 5;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q;
   logic [LEN_W-1:0]  num_q;
   logic [LEN_W-1:0]  issued_q;
   logic [LEN_W-1:0]  received_q;
   logic [OW-1:0]     outstanding_q;
   logic              rsp_vld_q;
   logic [511:0]      rsp_data_q;

   logic              active;
   logic              issue_pend;
   logic              cap_ok;
   logic              credit_ok;
   logic              req_valid;
   logic              xfer;
   logic              rsp_accept;
   logic              start_acc;
   logic [CW-1:0]     credit_need;
   logic [OW-1:0]     awaiting;

   always_comb begin
      credit_need = CW'(bus.fifo_count) + (CW'(outstanding_q) + CW'(1)) * CW'(64);
      credit_ok   = credit_need < CW'(FIFO_DEPTH);
      cap_ok      = outstanding_q < OW'(MAX_OUTSTANDING);
      issue_pend  = (state_q == S_ISSUE) && (issued_q < num_q);
      active      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
      // outstanding still includes a line parked in the response register;
      // only lines without a response yet may legally receive one.
      awaiting    = outstanding_q - OW'(rsp_vld_q);
      rsp_accept  = bus.rd_rsp_valid && active && (awaiting != '0);
      start_acc   = (state_q == S_IDLE) && start;
   end

   // FSM: state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = (num_lines == '0) ? S_DONE : S_ISSUE;
         S_ISSUE: if (issued_q == num_q) state_d = S_DRAIN;
         S_DRAIN: if (received_q == num_q) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
      done      = (state_q == S_DONE);
      req_valid = issue_pend && cap_ok && credit_ok;
      xfer      = req_valid && bus.rd_req_ready;
   end

   assign bus.rd_req_valid  = req_valid;
   assign bus.rd_req_addr   = base_q + ADDR_W'(issued_q);
   assign bus.fifo_enq_en   = rsp_vld_q;
   assign bus.fifo_enq_data = rsp_data_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q        <= '0;
         num_q         <= '0;
         issued_q      <= '0;
         received_q    <= '0;
         outstanding_q <= '0;
         rsp_vld_q     <= 1'b0;
         rsp_data_q    <= '0;
      end else begin
         if (start_acc && (num_lines != '0)) begin
            base_q        <= base_addr;
            num_q         <= num_lines;
            issued_q      <= '0;
            received_q    <= '0;
            outstanding_q <= '0;
         end else begin
            if (xfer)      issued_q   <= issued_q + LEN_W'(1);
            if (rsp_vld_q) received_q <= received_q + LEN_W'(1);
            // in-flight count spans request transfer to its FIFO enqueue
            unique case ({xfer, rsp_vld_q})
               2'b10:   outstanding_q <= outstanding_q + OW'(1);
               2'b01:   outstanding_q <= outstanding_q - OW'(1);
               default: outstanding_q <= outstanding_q;
            endcase
         end
         rsp_vld_q <= rsp_accept;
         if (rsp_accept) rsp_data_q <= bus.rd_rsp_data;
      end
   end

`ifdef SW_RD_CTRL_PERF_EN
   logic [31:0] perf_busy_q;
   logic [31:0] perf_stall_q;
   logic        stall;

   assign stall = issue_pend && !(cap_ok && credit_ok);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_busy_q  <= '0;
         perf_stall_q <= '0;
      end else if (start_acc) begin
         perf_busy_q  <= '0;
         perf_stall_q <= '0;
      end else begin
         if (busy && (perf_busy_q != '1))   perf_busy_q  <= perf_busy_q + 32'd1;
         if (stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_busy_cycles  = perf_busy_q;
   assign perf_credit_stall = perf_stall_q;
`endif

   // a response with no request waiting for it is a memory-port protocol error
   a_rsp_has_request: assert property (@(posedge clk) disable iff (!reset_n)
      (bus.rd_rsp_valid && active) |-> (awaiting != '0));

endmodule

// File: tb/tb_smith_waterman_rd_ctrl.sv
module tb_smith_waterman_rd_ctrl;
   localparam int ADDR_W     = 42;
   localparam int LEN_W      = 32;
   localparam int FIFO_DEPTH = 512;
   localparam int MAX_OUT    = 8;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [LEN_W-1:0]  num_lines = '0;
   logic              busy;
   logic              done;
`ifdef SW_RD_CTRL_PERF_EN
   logic [31:0]       perf_busy_cycles;
   logic [31:0]       perf_credit_stall;
`endif

   smith_waterman_rd_ctrl_if #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

   smith_waterman_rd_ctrl #(
      .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start),
      .base_addr(base_addr),
      .num_lines(num_lines),
      .busy(busy),
      .done(done),
`ifdef SW_RD_CTRL_PERF_EN
      .perf_busy_cycles(perf_busy_cycles),
      .perf_credit_stall(perf_credit_stall),
`endif
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           due;
      logic [511:0] d;
   } rsp_t;

   int checks = 0;
   int failures = 0;

   logic [ADDR_W-1:0] obs_addr[$];
   logic [511:0]      obs_enq[$];
   logic [511:0]      exp_q[$];
   rsp_t              pend[$];
   int                cyc = 0;
   int                rsp_budget = 0;
   int                done_cnt = 0;
   int                first_done_cyc = -1;
   int                last_enq_cyc = -1;
   bit                busy_at_done = 1'b0;
   bit                busy_prev_at_done = 1'b0;
   bit                prev_busy = 1'b0;

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int unsigned i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic clear_tb();
      obs_addr.delete();
      obs_enq.delete();
      exp_q.delete();
      pend.delete();
      done_cnt = 0;
      first_done_cyc = -1;
      last_enq_cyc = -1;
      prev_busy = 1'b0;
   endtask

   // One clock: records handshakes/enqueues/done, plays memory responses.
   // Entered and left just after a falling edge.
   task automatic tick();
      rsp_t p;
      #2;
      if (bus.rd_req_valid && bus.rd_req_ready) begin
         obs_addr.push_back(bus.rd_req_addr);
         pend.push_back('{due: cyc + 2, d: rand512()});
      end
      if (bus.fifo_enq_en) begin
         obs_enq.push_back(bus.fifo_enq_data);
         last_enq_cyc = cyc;
      end
      if (done) begin
         if (done_cnt == 0) begin
            first_done_cyc = cyc;
            busy_at_done = busy;
            busy_prev_at_done = prev_busy;
         end
         done_cnt++;
      end
      prev_busy = busy;
      bus.rd_rsp_valid = 1'b0;
      if (rsp_budget > 0 && pend.size() > 0 && pend[0].due <= cyc) begin
         p = pend.pop_front();
         bus.rd_rsp_valid = 1'b1;
         bus.rd_rsp_data = p.d;
         exp_q.push_back(p.d);
         rsp_budget--;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      start = 1'b0;
      bus.rd_rsp_valid = 1'b0;
      bus.rd_req_ready = 1'b1;
      bus.fifo_count = '0;
      rsp_budget = 0;
      clear_tb();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic run_until_done(input int max_ticks, output bit ok);
      for (int i = 0; i < max_ticks && done_cnt == 0; i++) tick();
      ok = (done_cnt > 0);
      repeat (3) tick();
   endtask

   task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n);
      base_addr = b;
      num_lines = n;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, bus.rd_req_valid, bus.fifo_enq_en} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, bus.rd_req_valid, bus.fifo_enq_en});
      end
      checks++;
      if (bus.rd_req_addr !== '0) begin
         failures++;
         $display("FAIL reset_addr: got %0h expected 0", bus.rd_req_addr);
      end
      checks++;
      if (bus.fifo_enq_data !== '0) begin
         failures++;
         $display("FAIL reset_enq_data: got %0h expected 0", bus.fifo_enq_data);
      end
      do_reset();
   endtask

   task automatic test_basic_stream();
      bit ok;
      logic [ADDR_W-1:0] ea;
      do_reset();
      rsp_budget = 1000;
      pulse_start(42'h100, 4);
      run_until_done(200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL basic_timeout: got no done expected done"); end
      checks++;
      if (obs_addr.size() != 4) begin
         failures++;
         $display("FAIL basic_req_count: got %0d expected 4", obs_addr.size());
      end
      for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
         ea = 42'h100 + ADDR_W'(i);
         checks++;
         if (obs_addr[i] !== ea) begin
            failures++;
            $display("FAIL basic_addr[%0d]: got %0h expected %0h", i, obs_addr[i], ea);
         end
      end
      checks++;
      if (obs_enq.size() != 4 || exp_q.size() != 4) begin
         failures++;
         $display("FAIL basic_enq_count: got %0d expected 4", obs_enq.size());
      end
      while (obs_enq.size() > 0 && exp_q.size() > 0) begin
         logic [511:0] o, e;
         o = obs_enq.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL basic_enq_data: got %0h expected %0h", o, e);
         end
      end
      checks++;
      if (done_cnt != 1) begin failures++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
      checks++;
      if (busy_at_done !== 1'b0 || busy_prev_at_done !== 1'b1) begin
         failures++;
         $display("FAIL basic_busy_edge: got at=%b prev=%b expected at=0 prev=1", busy_at_done, busy_prev_at_done);
      end
      checks++;
      if (first_done_cyc <= last_enq_cyc) begin
         failures++;
         $display("FAIL basic_done_after_enq: got done@%0d enq@%0d expected done later", first_done_cyc, last_enq_cyc);
      end
   endtask

   task automatic test_credit_limit();
      do_reset();
      pulse_start(42'h2000, 20);
      repeat (30) tick();
      checks++;
      if (obs_addr.size() != 7) begin
         failures++;
         $display("FAIL credit_inflight: got %0d expected 7", obs_addr.size());
      end
      checks++;
      if (bus.rd_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL credit_valid_low: got %b expected 0", bus.rd_req_valid);
      end
      // start while busy must be ignored
      pulse_start(42'h0, 0);
      repeat (3) tick();
      checks++;
      if (busy !== 1'b1 || done_cnt != 0) begin
         failures++;
         $display("FAIL credit_start_ignored: got busy=%b done=%0d expected busy=1 done=0", busy, done_cnt);
      end
      rsp_budget = 1;
      repeat (10) tick();
      checks++;
      if (obs_addr.size() != 8 || obs_enq.size() != 1) begin
         failures++;
         $display("FAIL credit_refill: got req=%0d enq=%0d expected req=8 enq=1", obs_addr.size(), obs_enq.size());
      end
      checks++;
      if (obs_addr.size() == 8 && obs_addr[7] !== 42'h2007) begin
         failures++;
         $display("FAIL credit_refill_addr: got %0h expected 2007", obs_addr[7]);
      end
   endtask

   task automatic test_occupied_fifo();
      do_reset();
      bus.fifo_count = 10'd448;
      pulse_start(42'h500, 4);
      repeat (10) tick();
      checks++;
      if (obs_addr.size() != 0 || bus.rd_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL occ_448: got req=%0d valid=%b expected req=0 valid=0", obs_addr.size(), bus.rd_req_valid);
      end
      bus.fifo_count = 10'd384;
      repeat (10) tick();
      checks++;
      if (obs_addr.size() != 1 || bus.rd_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL occ_384: got req=%0d valid=%b expected req=1 valid=0", obs_addr.size(), bus.rd_req_valid);
      end
   endtask

   task automatic test_zero_length();
      do_reset();
      pulse_start(42'h700, 0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || bus.rd_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL zero_done: got done=%b busy=%b valid=%b expected 1 0 0", done, busy, bus.rd_req_valid);
      end
      repeat (4) tick();
      checks++;
      if (done_cnt != 1 || obs_addr.size() != 0) begin
         failures++;
         $display("FAIL zero_once: got done=%0d req=%0d expected done=1 req=0", done_cnt, obs_addr.size());
      end
   endtask

   task automatic test_reset_mid_run();
      bit ok;
      logic [ADDR_W-1:0] ea;
      do_reset();
      pulse_start(42'h900, 10);
      for (int i = 0; i < 20 && obs_addr.size() < 3; i++) tick();
      checks++;
      if (obs_addr.size() != 3 || busy !== 1'b1) begin
         failures++;
         $display("FAIL midrst_progress: got req=%0d busy=%b expected req=3 busy=1", obs_addr.size(), busy);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, bus.rd_req_valid, bus.fifo_enq_en} !== 4'b0000 || bus.rd_req_addr !== '0) begin
         failures++;
         $display("FAIL midrst_outputs: got %b addr=%0h expected 0000 addr=0",
                  {busy, done, bus.rd_req_valid, bus.fifo_enq_en}, bus.rd_req_addr);
      end
      @(negedge clk);
      clear_tb();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      bus.rd_rsp_valid = 1'b1;
      bus.rd_rsp_data = rand512();
      @(negedge clk);
      bus.rd_rsp_valid = 1'b0;
      repeat (3) tick();
      checks++;
      if (obs_enq.size() != 0) begin
         failures++;
         $display("FAIL midrst_stray: got enq=%0d expected 0", obs_enq.size());
      end
      // restart across the address wrap point
      rsp_budget = 100;
      pulse_start('1, 2);
      run_until_done(100, ok);
      checks++;
      if (!ok || done_cnt != 1 || obs_addr.size() != 2 || obs_enq.size() != 2) begin
         failures++;
         $display("FAIL midrst_restart: got done=%0d req=%0d enq=%0d expected 1 2 2",
                  done_cnt, obs_addr.size(), obs_enq.size());
      end
      for (int i = 0; i < obs_addr.size() && i < 2; i++) begin
         ea = '1;
         ea = ea + ADDR_W'(i);
         checks++;
         if (obs_addr[i] !== ea) begin
            failures++;
            $display("FAIL midrst_wrap_addr[%0d]: got %0h expected %0h", i, obs_addr[i], ea);
         end
      end
      for (int i = 0; i < obs_enq.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_enq[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL midrst_enq_data[%0d]: got %0h expected %0h", i, obs_enq[i], exp_q[i]);
         end
      end
   endtask

`ifdef SW_RD_CTRL_PERF_EN
   task automatic test_perf();
      bit ok;
      do_reset();
      bus.fifo_count = 10'd448;
      pulse_start(42'hA00, 3);
      repeat (10) tick();
      checks++;
      if (perf_credit_stall !== 32'd10 || perf_busy_cycles !== 32'd10) begin
         failures++;
         $display("FAIL perf_stall: got stall=%0d busy=%0d expected 10 10", perf_credit_stall, perf_busy_cycles);
      end
      bus.fifo_count = '0;
      rsp_budget = 100;
      run_until_done(100, ok);
      pulse_start(42'h0, 0);
      checks++;
      if (!ok || perf_credit_stall !== 32'd0 || perf_busy_cycles !== 32'd0) begin
         failures++;
         $display("FAIL perf_clear: got stall=%0d busy=%0d expected 0 0", perf_credit_stall, perf_busy_cycles);
      end
   endtask
`endif

   initial begin
      bus.rd_req_ready = 1'b1;
      bus.rd_rsp_valid = 1'b0;
      bus.rd_rsp_data = '0;
      bus.fifo_count = '0;
      test_reset();
      test_basic_stream();
      test_credit_limit();
      test_occupied_fifo();
      test_zero_length();
      test_reset_mid_run();
`ifdef SW_RD_CTRL_PERF_EN
      test_perf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
